ctrl_pipe_id: RTL and testbench

Parametrised decode-stage controller for the pipelined RV32 core. It decodes RV32I plus an optional M extension into the existing control encodings and registers the result into the ID/EX control latch. It also generates the hazard signals: load-use bubble, branch/jump flush, and multi-cycle MUL/DIV hold. It sits between the IF/ID register and the EX stage, beside the register file.

---
 rtl/ctrl_pipe_id.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_ctrl_pipe_id.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_id.sv
// Decode-stage controller: RV32I(+M) decode into the ID/EX control latch,
// plus load-use, redirect-flush and multi-cycle MUL/DIV hazard generation.
module ctrl_pipe_id #(
    parameter bit          ENABLE_M = 1'b1,
    parameter int unsigned MUL_LAT  = 2,
    parameter int unsigned DIV_LAT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    input  logic        ex_redirect,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memwrite,
    output logic        ex_memread,
    output logic        ex_alusrc,
    output logic [5:0]  ex_extop,
    output logic [4:0]  ex_aluop,
    output logic [2:0]  ex_npcop,
    output logic [1:0]  ex_wdsel,
    output logic [2:0]  ex_dmtype,
    output logic        ex_mdu,
    output logic [2:0]  ex_mduop,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic        ex_illegal,
    output logic        mdu_busy
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [4:0] ALU_NOP  = 5'd0,  ALU_LUI  = 5'd1,  ALU_AUIPC = 5'd2;
    localparam logic [4:0] ALU_ADD  = 5'd3,  ALU_SUB  = 5'd4,  ALU_BNE   = 5'd5;
    localparam logic [4:0] ALU_BLT  = 5'd6,  ALU_BGE  = 5'd7,  ALU_BLTU  = 5'd8;
    localparam logic [4:0] ALU_BGEU = 5'd9,  ALU_SLT  = 5'd10, ALU_SLTU  = 5'd11;
    localparam logic [4:0] ALU_XOR  = 5'd12, ALU_OR   = 5'd13, ALU_AND   = 5'd14;
    localparam logic [4:0] ALU_SLL  = 5'd15, ALU_SRL  = 5'd16, ALU_SRA   = 5'd17;

    localparam logic [5:0] EXT_SHAMT = 6'b100000, EXT_I = 6'b010000, EXT_S = 6'b001000;
    localparam logic [5:0] EXT_B     = 6'b000100, EXT_U = 6'b000010, EXT_J = 6'b000001;

    typedef enum logic {S_RUN, S_MDU_BUSY} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_legal, w_regwrite, w_memwrite, w_memread, w_alusrc, w_mdu;
    logic       w_uses_rs1, w_uses_rs2, w_has_rd;
    logic [5:0] w_extop;
    logic [4:0] w_aluop;
    logic [2:0] w_npcop, w_dmtype;
    logic [1:0] w_wdsel;
    logic [4:0] w_rd;

    assign w_opcode = id_inst[6:0];
    assign w_f3     = id_inst[14:12];
    assign w_f7     = id_inst[31:25];

    // Instruction decode; fields may be set for invalid funct encodings and are gated by w_legal.
    always_comb begin
        w_legal    = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_memread  = 1'b0;
        w_alusrc   = 1'b0;
        w_mdu      = 1'b0;
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        w_has_rd   = 1'b0;
        w_extop    = '0;
        w_aluop    = ALU_NOP;
        w_npcop    = 3'b000;
        w_wdsel    = 2'b00;
        w_dmtype   = 3'b000;
        case (w_opcode)
            OP_LUI, OP_AUIPC: begin
                w_legal    = 1'b1;
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_extop    = EXT_U;
                w_aluop    = (w_opcode == OP_LUI) ? ALU_LUI : ALU_AUIPC;
                w_has_rd   = 1'b1;
            end
            OP_JAL: begin
                w_legal    = 1'b1;
                w_regwrite = 1'b1;
                w_extop    = EXT_J;
                w_aluop    = ALU_ADD;
                w_npcop    = 3'b010;
                w_wdsel    = 2'b10;
                w_has_rd   = 1'b1;
            end
            OP_JALR: begin
                w_legal    = (w_f3 == 3'b000);
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_extop    = EXT_I;
                w_aluop    = ALU_ADD;
                w_npcop    = 3'b100;
                w_wdsel    = 2'b10;
                w_has_rd   = 1'b1;
                w_uses_rs1 = 1'b1;
            end
            OP_BRANCH: begin
                w_legal    = 1'b1;
                w_extop    = EXT_B;
                w_npcop    = 3'b001;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
                case (w_f3)
                    3'b000:  w_aluop = ALU_SUB;
                    3'b001:  w_aluop = ALU_BNE;
                    3'b100:  w_aluop = ALU_BLT;
                    3'b101:  w_aluop = ALU_BGE;
                    3'b110:  w_aluop = ALU_BLTU;
                    3'b111:  w_aluop = ALU_BGEU;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                w_legal    = 1'b1;
                w_regwrite = 1'b1;
                w_memread  = 1'b1;
                w_alusrc   = 1'b1;
                w_extop    = EXT_I;
                w_aluop    = ALU_ADD;
                w_wdsel    = 2'b01;
                w_has_rd   = 1'b1;
                w_uses_rs1 = 1'b1;
                case (w_f3)
                    3'b000:  w_dmtype = 3'b011;
                    3'b001:  w_dmtype = 3'b001;
                    3'b010:  w_dmtype = 3'b000;
                    3'b100:  w_dmtype = 3'b100;
                    3'b101:  w_dmtype = 3'b010;
                    default: w_legal  = 1'b0;
                endcase
            end
            OP_STORE: begin
                w_legal    = 1'b1;
                w_memwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_extop    = EXT_S;
                w_aluop    = ALU_ADD;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
                case (w_f3)
                    3'b000:  w_dmtype = 3'b011;
                    3'b001:  w_dmtype = 3'b001;
                    3'b010:  w_dmtype = 3'b000;
                    default: w_legal  = 1'b0;
                endcase
            end
            OP_IMM: begin
                w_legal    = 1'b1;
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_extop    = EXT_I;
                w_has_rd   = 1'b1;
                w_uses_rs1 = 1'b1;
                case (w_f3)
                    3'b000: w_aluop = ALU_ADD;
                    3'b010: w_aluop = ALU_SLT;
                    3'b011: w_aluop = ALU_SLTU;
                    3'b100: w_aluop = ALU_XOR;
                    3'b110: w_aluop = ALU_OR;
                    3'b111: w_aluop = ALU_AND;
                    3'b001: begin
                        w_extop = EXT_SHAMT;
                        w_aluop = ALU_SLL;
                        w_legal = (w_f7 == 7'b0000000);
                    end
                    default: begin
                        w_extop = EXT_SHAMT;
                        w_aluop = w_f7[5] ? ALU_SRA : ALU_SRL;
                        w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                    end
                endcase
            end
            OP_REG: begin
                w_regwrite = 1'b1;
                w_has_rd   = 1'b1;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
                if (w_f7 == 7'b0000001) begin
                    w_legal = ENABLE_M;
                    w_mdu   = 1'b1;
                end else begin
                    w_legal = 1'b1;
                    case ({w_f7, w_f3})
                        10'b0000000_000: w_aluop = ALU_ADD;
                        10'b0100000_000: w_aluop = ALU_SUB;
                        10'b0000000_001: w_aluop = ALU_SLL;
                        10'b0000000_010: w_aluop = ALU_SLT;
                        10'b0000000_011: w_aluop = ALU_SLTU;
                        10'b0000000_100: w_aluop = ALU_XOR;
                        10'b0000000_101: w_aluop = ALU_SRL;
                        10'b0100000_101: w_aluop = ALU_SRA;
                        10'b0000000_110: w_aluop = ALU_OR;
                        10'b0000000_111: w_aluop = ALU_AND;
                        default:         w_legal = 1'b0;
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign w_rd = w_has_rd ? id_inst[11:7] : 5'd0;

    logic             w_ok, w_run, w_lu, w_load, w_mdu_multi;
    logic [CNT_W-1:0] w_mdu_cnt;

    assign w_ok  = id_valid & w_legal;
    assign w_run = (r_state == S_RUN);

    // Load in EX whose destination feeds the instruction now in ID.
    assign w_lu = ex_valid & ex_memread & (ex_rd != 5'd0) & w_ok &
                  ((w_uses_rs1 & (id_inst[19:15] == ex_rd)) |
                   (w_uses_rs2 & (id_inst[24:20] == ex_rd)));

    assign w_load      = w_run & ~ex_redirect & ~w_lu;
    assign w_mdu_multi = w_f3[2] ? (DIV_LAT > 1) : (MUL_LAT > 1);
    assign w_mdu_cnt   = w_f3[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

    assign pc_stall   = ~w_run | (~ex_redirect & w_lu);
    assign ifid_stall = pc_stall;
    assign ifid_flush = w_run & ex_redirect;
    assign mdu_busy   = ~w_run;

    // RUN/MDU_BUSY sequencing: cnt holds the remaining busy cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_load && w_ok && w_mdu && w_mdu_multi) begin
                        r_state <= S_MDU_BUSY;
                        r_cnt   <= w_mdu_cnt;
                    end
                end
                S_MDU_BUSY: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) r_state <= S_RUN;
                end
            endcase
        end
    end

    // ID/EX control latch: bubble on reset/redirect/load-use, hold while MDU busy.
    always_ff @(posedge clk) begin
        if (rst || (w_run && !w_load)) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_extop    <= '0;
            ex_aluop    <= '0;
            ex_npcop    <= '0;
            ex_wdsel    <= '0;
            ex_dmtype   <= '0;
            ex_mdu      <= 1'b0;
            ex_mduop    <= '0;
            ex_rd       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_illegal  <= 1'b0;
        end else if (w_load) begin
            ex_valid    <= id_valid;
            ex_regwrite <= w_ok & w_regwrite;
            ex_memwrite <= w_ok & w_memwrite;
            ex_memread  <= w_ok & w_memread;
            ex_mdu      <= w_ok & w_mdu;
            ex_alusrc   <= w_legal & w_alusrc;
            ex_extop    <= w_legal ? w_extop  : '0;
            ex_aluop    <= w_legal ? w_aluop  : '0;
            ex_npcop    <= w_legal ? w_npcop  : '0;
            ex_wdsel    <= w_legal ? w_wdsel  : '0;
            ex_dmtype   <= w_legal ? w_dmtype : '0;
            ex_mduop    <= (w_legal && w_mdu) ? w_f3 : '0;
            ex_rd       <= w_legal ? w_rd : '0;
            ex_rs1      <= w_legal ? id_inst[19:15] : '0;
            ex_rs2      <= w_legal ? id_inst[24:20] : '0;
            ex_illegal  <= id_valid & ~w_legal;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_id.sv
// Bench for ctrl_pipe_id: directed hazard scenarios, then random instruction
// streams checked against an instruction-kind-level reference model.
module tb_ctrl_pipe_id;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 8;

    typedef struct packed {
        logic       valid, regwrite, memwrite, memread, alusrc;
        logic [5:0] extop;
        logic [4:0] aluop;
        logic [2:0] npcop;
        logic [1:0] wdsel;
        logic [2:0] dmtype;
        logic       mdu;
        logic [2:0] mduop;
        logic [4:0] rd, rs1, rs2;
        logic       illegal;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst, id_valid, ex_redirect;
    logic [31:0] id_inst;

    logic pc_stall, ifid_stall, ifid_flush, ex_valid, ex_regwrite, ex_memwrite, ex_memread;
    logic ex_alusrc, ex_mdu, ex_illegal, mdu_busy;
    logic [5:0] ex_extop;
    logic [4:0] ex_aluop, ex_rd, ex_rs1, ex_rs2;
    logic [2:0] ex_npcop, ex_dmtype, ex_mduop;
    logic [1:0] ex_wdsel;

    logic nm_pc_stall, nm_ifid_stall, nm_ifid_flush, nm_ex_valid, nm_ex_regwrite, nm_ex_memwrite;
    logic nm_ex_memread, nm_ex_alusrc, nm_ex_mdu, nm_ex_illegal, nm_mdu_busy;
    logic [5:0] nm_ex_extop;
    logic [4:0] nm_ex_aluop, nm_ex_rd, nm_ex_rs1, nm_ex_rs2;
    logic [2:0] nm_ex_npcop, nm_ex_dmtype, nm_ex_mduop;
    logic [1:0] nm_ex_wdsel;

    ctrl_pipe_id #(.ENABLE_M(1'b1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .ex_redirect(ex_redirect),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memwrite(ex_memwrite),
        .ex_memread(ex_memread), .ex_alusrc(ex_alusrc), .ex_extop(ex_extop),
        .ex_aluop(ex_aluop), .ex_npcop(ex_npcop), .ex_wdsel(ex_wdsel), .ex_dmtype(ex_dmtype),
        .ex_mdu(ex_mdu), .ex_mduop(ex_mduop), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_illegal(ex_illegal), .mdu_busy(mdu_busy)
    );

    ctrl_pipe_id #(.ENABLE_M(1'b0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut_nm (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .ex_redirect(ex_redirect),
        .pc_stall(nm_pc_stall), .ifid_stall(nm_ifid_stall), .ifid_flush(nm_ifid_flush),
        .ex_valid(nm_ex_valid), .ex_regwrite(nm_ex_regwrite), .ex_memwrite(nm_ex_memwrite),
        .ex_memread(nm_ex_memread), .ex_alusrc(nm_ex_alusrc), .ex_extop(nm_ex_extop),
        .ex_aluop(nm_ex_aluop), .ex_npcop(nm_ex_npcop), .ex_wdsel(nm_ex_wdsel),
        .ex_dmtype(nm_ex_dmtype), .ex_mdu(nm_ex_mdu), .ex_mduop(nm_ex_mduop), .ex_rd(nm_ex_rd),
        .ex_rs1(nm_ex_rs1), .ex_rs2(nm_ex_rs2), .ex_illegal(nm_ex_illegal), .mdu_busy(nm_mdu_busy)
    );

    always #5 clk = ~clk;

    ex_t obs;
    assign obs = {ex_valid, ex_regwrite, ex_memwrite, ex_memread, ex_alusrc, ex_extop, ex_aluop,
                  ex_npcop, ex_wdsel, ex_dmtype, ex_mdu, ex_mduop, ex_rd, ex_rs1, ex_rs2, ex_illegal};

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Build a random instruction of kind k and its expected EX controls (id_valid=1).
    function automatic void gen(input int k, output logic [31:0] w, output ex_t d,
                                output bit u1, output bit u2, output int lat);
        logic [4:0]  rd, r1, r2, al;
        logic [11:0] im;
        logic [19:0] iu;
        logic [2:0]  f3, dm;
        logic [6:0]  f7;
        rd = 5'($urandom_range(0, 7));
        r1 = 5'($urandom_range(0, 3));
        r2 = 5'($urandom_range(0, 3));
        im = 12'($urandom);
        iu = 20'($urandom);
        d = '0; d.valid = 1'b1; u1 = 0; u2 = 0; lat = 0;
        f3 = 3'b000; f7 = 7'b0; dm = 3'b000; al = 5'd0;
        w = 32'h0;
        if (k <= 1) begin
            w = {iu, rd, (k == 0) ? 7'h37 : 7'h17};
            d.regwrite = 1; d.alusrc = 1; d.extop = 6'b000010; d.aluop = (k == 0) ? 5'd1 : 5'd2; d.rd = rd;
        end else if (k == 2) begin
            w = {iu, rd, 7'h6F};
            d.regwrite = 1; d.extop = 6'b000001; d.aluop = 5'd3; d.npcop = 3'b010; d.wdsel = 2'b10; d.rd = rd;
        end else if (k == 3) begin
            w = {im, r1, 3'b000, rd, 7'h67};
            d.regwrite = 1; d.alusrc = 1; d.extop = 6'b010000; d.aluop = 5'd3; d.npcop = 3'b100;
            d.wdsel = 2'b10; d.rd = rd; u1 = 1;
        end else if (k <= 7) begin
            case (k)
                4: begin f3 = 3'b000; al = 5'd4; end
                5: begin f3 = 3'b001; al = 5'd5; end
                6: begin f3 = 3'b110; al = 5'd8; end
                default: begin f3 = 3'b101; al = 5'd7; end
            endcase
            w = {im[11:5], r2, r1, f3, im[4:0], 7'h63};
            d.extop = 6'b000100; d.aluop = al; d.npcop = 3'b001; u1 = 1; u2 = 1;
        end else if (k <= 10) begin
            case (k)
                8: begin f3 = 3'b010; dm = 3'b000; end
                9: begin f3 = 3'b001; dm = 3'b001; end
                default: begin f3 = 3'b100; dm = 3'b100; end
            endcase
            w = {im, r1, f3, rd, 7'h03};
            d.regwrite = 1; d.memread = 1; d.alusrc = 1; d.extop = 6'b010000; d.aluop = 5'd3;
            d.wdsel = 2'b01; d.dmtype = dm; d.rd = rd; u1 = 1;
        end else if (k <= 12) begin
            f3 = (k == 11) ? 3'b010 : 3'b000;
            dm = (k == 11) ? 3'b000 : 3'b011;
            w = {im[11:5], r2, r1, f3, im[4:0], 7'h23};
            d.memwrite = 1; d.alusrc = 1; d.extop = 6'b001000; d.aluop = 5'd3; d.dmtype = dm; u1 = 1; u2 = 1;
        end else if (k <= 15) begin
            case (k)
                13: begin f3 = 3'b000; al = 5'd3; end
                14: begin f3 = 3'b100; al = 5'd12; end
                default: begin f3 = 3'b011; al = 5'd11; end
            endcase
            w = {im, r1, f3, rd, 7'h13};
            d.regwrite = 1; d.alusrc = 1; d.extop = 6'b010000; d.aluop = al; d.rd = rd; u1 = 1;
        end else if (k <= 17) begin
            f7 = (k == 16) ? 7'b0000000 : 7'b0100000;
            f3 = (k == 16) ? 3'b001 : 3'b101;
            w = {f7, r2, r1, f3, rd, 7'h13};
            d.regwrite = 1; d.alusrc = 1; d.extop = 6'b100000; d.aluop = (k == 16) ? 5'd15 : 5'd17;
            d.rd = rd; u1 = 1;
        end else if (k <= 23) begin
            case (k)
                18: begin f7 = 7'b0000000; f3 = 3'b000; al = 5'd3;  end
                19: begin f7 = 7'b0100000; f3 = 3'b000; al = 5'd4;  end
                20: begin f7 = 7'b0000000; f3 = 3'b010; al = 5'd10; end
                21: begin f7 = 7'b0000000; f3 = 3'b111; al = 5'd14; end
                22: begin f7 = 7'b0000000; f3 = 3'b101; al = 5'd16; end
                default: begin f7 = 7'b0000000; f3 = 3'b110; al = 5'd13; end
            endcase
            w = {f7, r2, r1, f3, rd, 7'h33};
            d.regwrite = 1; d.aluop = al; d.rd = rd; u1 = 1; u2 = 1;
        end else if (k <= 27) begin
            case (k)
                24: begin f3 = 3'b000; lat = MUL_LAT; end
                25: begin f3 = 3'b001; lat = MUL_LAT; end
                26: begin f3 = 3'b100; lat = DIV_LAT; end
                default: begin f3 = 3'b111; lat = DIV_LAT; end
            endcase
            w = {7'b0000001, r2, r1, f3, rd, 7'h33};
            d.regwrite = 1; d.mdu = 1; d.mduop = f3; d.rd = rd; u1 = 1; u2 = 1;
        end else if (k == 28) begin
            w = {25'($urandom), 7'h7F};
            d.illegal = 1;
        end else begin
            w = {im, r1, 3'b011, rd, 7'h03};
            d.illegal = 1;
        end
        if (!d.illegal) begin
            d.rs1 = w[19:15];
            d.rs2 = w[24:20];
        end
    endfunction

    ex_t         exp_ex, cur_d;
    logic [31:0] cur_w;
    bit          cur_u1, cur_u2, held, do_rst, lu, stl, flush;
    int          cur_lat, busy_left, busy_cnt;

    initial begin
        // Reset with a valid instruction present: EX must stay empty.
        rst = 1; id_valid = 1; id_inst = 32'h0000A283; ex_redirect = 0;
        step();
        chk("reset_ex_c1", 64'(obs), 64'(0));
        step();
        chk("reset_ex_c2", 64'(obs), 64'(0));
        rst = 0;
        step();
        chk("lw_valid", 64'(ex_valid), 64'(1));
        chk("lw_memread", 64'(ex_memread), 64'(1));
        chk("lw_rd", 64'(ex_rd), 64'(5));

        // Load-use: add x6,x5,x2 behind lw x5
        id_inst = 32'h00228333;
        #2;
        chk("lu_pc_stall", 64'(pc_stall), 64'(1));
        chk("lu_ifid_stall", 64'(ifid_stall), 64'(1));
        step();
        chk("lu_bubble", 64'(ex_valid), 64'(0));
        chk("lu_released", 64'(pc_stall), 64'(0));
        step();
        chk("add_valid", 64'(ex_valid), 64'(1));
        chk("add_aluop", 64'(ex_aluop), 64'(5'b00011));
        chk("add_wdsel", 64'(ex_wdsel), 64'(2'b00));

        // Redirect flushes IF/ID and bubbles EX without stalling
        ex_redirect = 1;
        #2;
        chk("redir_flush", 64'(ifid_flush), 64'(1));
        chk("redir_nostall", 64'(pc_stall), 64'(0));
        step();
        ex_redirect = 0;
        chk("redir_bubble", 64'(ex_valid), 64'(0));

        // MUL, 2-cycle occupancy; non-M instance flags it illegal
        id_inst = 32'h026283B3;
        step();
        chk("mul_mdu", 64'(ex_mdu), 64'(1));
        chk("mul_mduop", 64'(ex_mduop), 64'(0));
        chk("mul_busy", 64'(mdu_busy), 64'(1));
        chk("mul_stall", 64'(pc_stall), 64'(1));
        chk("nm_illegal", 64'(nm_ex_illegal), 64'(1));
        chk("nm_valid", 64'(nm_ex_valid), 64'(1));
        chk("nm_regwrite", 64'(nm_ex_regwrite), 64'(0));
        chk("nm_nobusy", 64'(nm_mdu_busy), 64'(0));
        id_inst = 32'h00228333;
        step();
        chk("mul_hold", 64'(ex_mdu), 64'(1));
        chk("mul_busy_end", 64'(mdu_busy), 64'(0));
        step();
        chk("after_mul", 64'(ex_aluop), 64'(5'b00011));

        // DIV, 8-cycle occupancy
        id_inst = 32'h0262C3B3;
        step();
        chk("div_mduop", 64'(ex_mduop), 64'(3'b100));
        id_inst = 32'h00228333;
        busy_cnt = 0;
        for (int i = 0; i < 20 && mdu_busy; i++) begin
            busy_cnt++;
            step();
        end
        chk("div_busy_cycles", 64'(busy_cnt), 64'(DIV_LAT - 1));
        chk("div_hold_last", 64'(ex_mduop), 64'(3'b100));

        // Reset during busy cycle 3 aborts the divide
        id_inst = 32'h0262C3B3;
        step();
        step();
        step();
        chk("div2_busy3", 64'(mdu_busy), 64'(1));
        rst = 1;
        step();
        rst = 0;
        chk("rst_abort_valid", 64'(ex_valid), 64'(0));
        chk("rst_abort_run", 64'(mdu_busy), 64'(0));

        // Unknown opcode
        id_inst = 32'h0000007F;
        step();
        chk("opc_illegal", 64'(ex_illegal), 64'(1));
        chk("opc_valid", 64'(ex_valid), 64'(1));
        chk("opc_regwrite", 64'(ex_regwrite), 64'(0));
        chk("opc_npcop", 64'(ex_npcop), 64'(0));
        chk("opc_nostall", 64'(pc_stall), 64'(0));

        // Random streams against the reference model
        rst = 1;
        step();
        rst = 0;
        exp_ex = '0; busy_left = 0; held = 0;
        cur_w = 32'h0; cur_d = '0; cur_u1 = 0; cur_u2 = 0; cur_lat = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!held) begin
                gen(int'($urandom_range(0, 29)), cur_w, cur_d, cur_u1, cur_u2, cur_lat);
                id_valid = ($urandom_range(0, 7) != 0);
            end
            id_inst     = cur_w;
            ex_redirect = ($urandom_range(0, 7) == 0);
            do_rst      = ($urandom_range(0, 59) == 0);
            rst         = do_rst;
            lu = (busy_left == 0) && exp_ex.valid && exp_ex.memread && (exp_ex.rd != 0) && id_valid &&
                 ((cur_u1 && cur_w[19:15] == exp_ex.rd) || (cur_u2 && cur_w[24:20] == exp_ex.rd));
            flush = (busy_left == 0) && ex_redirect;
            stl   = (busy_left > 0) || (!ex_redirect && lu);
            #2;
            if (!do_rst) begin
                chk("rnd_pc_stall", 64'(pc_stall), 64'(stl));
                chk("rnd_ifid_stall", 64'(ifid_stall), 64'(stl));
                chk("rnd_flush", 64'(ifid_flush), 64'(flush));
                chk("rnd_mdu_busy", 64'(mdu_busy), 64'(busy_left > 0));
            end
            if (do_rst) begin
                exp_ex = '0; busy_left = 0;
            end else if (busy_left > 0) begin
                busy_left--;
            end else if (ex_redirect || lu) begin
                exp_ex = '0;
            end else begin
                exp_ex = cur_d;
                if (!id_valid) begin
                    exp_ex.valid = 0; exp_ex.regwrite = 0; exp_ex.memwrite = 0;
                    exp_ex.memread = 0; exp_ex.mdu = 0; exp_ex.illegal = 0;
                end else if (cur_d.mdu && cur_lat > 1) begin
                    busy_left = cur_lat - 1;
                end
            end
            held = stl && !do_rst;
            step();
            rst = 0;
            chk("rnd_ex", 64'(obs), 64'(exp_ex));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
